// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM sequencer: scan-out reads take priority over the clear fill and the pixel writer.
// Optional line doubling (each stored line scanned twice) is enabled with FB_LINE_DOUBLE_EN.
module vga_fb_arbiter #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 153600,
    parameter int AW    = 19
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_pixel,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_pixel,
    input  logic             wr_sof,
    input  logic             clear_start,
    input  logic [WIDTH-1:0] clear_color,
    output logic             clear_busy,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic {NORMAL, CLEAR} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic [WIDTH-1:0] color_q, color_d;
    logic             rd_valid_q;
    logic [AW-1:0]    rd_base;
    logic [AW-1:0]    wr_addr;
    logic             wr_xfer;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef FB_LINE_DOUBLE_EN
    logic          parity_q, parity_d;
    logic [AW-1:0] line_base_q, line_base_d;

    // rd_base is where the read pointer effectively stands this cycle after frame/line events
    always_comb begin
        parity_d    = parity_q;
        line_base_d = line_base_q;
        rd_base     = rd_ptr_q;
        if (frame_start) begin
            rd_base     = '0;
            parity_d    = 1'b0;
            line_base_d = '0;
        end else if (line_start) begin
            if (!parity_q) begin
                line_base_d = rd_ptr_q;
                parity_d    = 1'b1;
            end else begin
                rd_base  = line_base_q;
                parity_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            parity_q    <= 1'b0;
            line_base_q <= '0;
        end else begin
            parity_q    <= parity_d;
            line_base_q <= line_base_d;
        end
    end
`else
    logic unused_line_start;
    assign unused_line_start = line_start;
    assign rd_base           = frame_start ? '0 : rd_ptr_q;
`endif

    assign wr_ready   = reset_n & ~rd_req & (state_q == NORMAL);
    assign wr_xfer    = wr_valid & wr_ready;
    assign wr_addr    = wr_sof ? '0 : wr_ptr_q;
    assign clear_busy = (state_q == CLEAR);
    assign rd_valid   = rd_valid_q;
    assign rd_pixel   = mem_rdata;

    always_comb begin
        mem_addr  = rd_base;
        mem_we    = 1'b0;
        mem_wdata = wr_pixel;
        rd_ptr_d  = rd_base;
        wr_ptr_d  = wr_ptr_q;
        clr_ptr_d = clr_ptr_q;
        color_d   = color_q;
        state_d   = state_q;
        if (rd_req) begin
            rd_ptr_d = ptr_inc(rd_base);
        end else if (state_q == CLEAR) begin
            mem_addr  = clr_ptr_q;
            mem_we    = 1'b1;
            mem_wdata = color_q;
            clr_ptr_d = ptr_inc(clr_ptr_q);
            if (clr_ptr_q == LAST) state_d = NORMAL;
        end else if (wr_xfer) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            wr_ptr_d  = ptr_inc(wr_addr);
        end
        // a second clear_start during a clear is deliberately dropped
        if (state_q == NORMAL && clear_start) begin
            state_d   = CLEAR;
            color_d   = clear_color;
            clr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= NORMAL;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            clr_ptr_q  <= '0;
            color_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            clr_ptr_q  <= clr_ptr_d;
            color_q    <= color_d;
            rd_valid_q <= rd_req;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a reduced DEPTH; line-doubling steps run when FB_LINE_DOUBLE_EN is defined.
module tb_vga_fb_arbiter;

    localparam int D = 2000;

    logic        clk_50 = 1'b0;
    logic        reset_n, frame_start, line_start, rd_req, wr_valid, wr_sof, clear_start;
    logic [2:0]  wr_pixel, clear_color, mem_rdata, mem_wdata, rd_pixel;
    logic        rd_valid, wr_ready, clear_busy, mem_we;
    logic [18:0] mem_addr;

    vga_fb_arbiter #(.WIDTH(3), .DEPTH(D), .AW(19)) dut (
        .clk_50(clk_50), .reset_n(reset_n), .frame_start(frame_start), .line_start(line_start),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_pixel(rd_pixel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pixel(wr_pixel), .wr_sof(wr_sof),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk_50 = ~clk_50;

    // external RAM with registered read data
    logic [2:0] ram [0:524287];
    always @(posedge clk_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int         total = 0, bad = 0;
    logic [2:0] ref_mem [0:524287];
    logic [2:0] rdq [$];
    int         m_rd_ptr = 0, m_wr_ptr = 0, m_clr = 0;
    bit         m_busy = 0, exp_rv = 0, last_xfer = 0, last_busy = 0;
    logic [2:0] m_color = 0;
    int         last_wa = -1, last_ra = -1;

    function automatic int inc(input int p);
        return (p == D - 1) ? 0 : p + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // per-cycle scoreboard, run at negedge+2 (inputs settled, away from posedge)
    task automatic check();
        int  a;
        bit  busy_n;
        if (!reset_n) begin
            m_busy = 0; m_rd_ptr = 0; m_wr_ptr = 0; m_clr = 0; exp_rv = 0;
            rdq.delete();
        end
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        if (rd_valid) begin
            if (rdq.size() == 0) chk("rd_unexpected", 32'(1), 32'(0));
            else chk("rd_pixel", 32'(rd_pixel), 32'(rdq.pop_front()));
        end
        chk("clear_busy", 32'(clear_busy), 32'(m_busy));
        chk("wr_ready", 32'(wr_ready), 32'(reset_n && !rd_req && !m_busy));
        last_busy = clear_busy;
        last_xfer = 0;
        busy_n    = m_busy;
        if (!reset_n) begin
            chk("rst_we", 32'(mem_we), 32'(0));
        end else begin
            if (frame_start) m_rd_ptr = 0;
            if (rd_req) begin
                a = m_rd_ptr;
                chk("rd_addr", 32'(mem_addr), 32'(a));
                chk("rd_we", 32'(mem_we), 32'(0));
                rdq.push_back(ref_mem[a]);
                m_rd_ptr = inc(a);
                last_ra  = a;
            end else if (m_busy) begin
                chk("clr_we", 32'(mem_we), 32'(1));
                chk("clr_addr", 32'(mem_addr), 32'(m_clr));
                chk("clr_data", 32'(mem_wdata), 32'(m_color));
                ref_mem[m_clr] = m_color;
                if (m_clr == D - 1) busy_n = 0;
                m_clr = inc(m_clr);
            end else if (wr_valid) begin
                a = wr_sof ? 0 : m_wr_ptr;
                chk("wr_we", 32'(mem_we), 32'(1));
                chk("wr_addr", 32'(mem_addr), 32'(a));
                chk("wr_data", 32'(mem_wdata), 32'(wr_pixel));
                ref_mem[a] = wr_pixel;
                m_wr_ptr  = inc(a);
                last_wa   = a;
                last_xfer = 1;
            end else begin
                chk("idle_we", 32'(mem_we), 32'(0));
            end
            if (!m_busy && clear_start) begin
                busy_n  = 1;
                m_clr   = 0;
                m_color = clear_color;
            end
        end
        m_busy = busy_n;
        exp_rv = reset_n && rd_req;
    endtask

    task automatic tick();
        #2;
        check();
        @(posedge clk_50);
        @(negedge clk_50);
    endtask

    task automatic idle();
        frame_start = 0; line_start = 0; rd_req = 0; wr_valid = 0; wr_sof = 0; clear_start = 0;
    endtask

    task automatic wr_burst(input int n, input bit sof_first, input int rd_at);
        int k = 0;
        int g = 0;
        while (k < n && g < n * 4 + 8) begin
            wr_valid = 1;
            wr_pixel = 3'((k % 7) + 1);
            wr_sof   = sof_first && (k == 0);
            rd_req   = (g == rd_at);
            tick();
            if (last_xfer) k++;
            g++;
        end
        if (k < n) chk("wr_burst_timeout", 32'(k), 32'(n));
        idle();
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) begin
            rd_req = 1;
            tick();
        end
        idle();
    endtask

    // run a clear; rd_req for 10 cycles from rd_from, optional second clear_start at n==again
    task automatic run_clear(input logic [2:0] col, input int rd_from, input int again, input int exp_len);
        int n = 0;
        clear_color = col; clear_start = 1; wr_valid = 1; wr_pixel = 3'd6;
        tick();
        clear_start = 0;
        while (n < D + 100) begin
            rd_req      = (n >= rd_from && n < rd_from + 10);
            clear_start = (n == again);
            tick();
            if (!last_busy) break;
            n++;
        end
        chk("clear_len", 32'(n), 32'(exp_len));
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset_n = 0; wr_pixel = 0; clear_color = 0;
        @(negedge clk_50);
        // reset state, with requests pending that must be ignored
        wr_valid = 1; rd_req = 1;
        tick(); tick();
        idle();
        tick();
        reset_n = 1;
        tick();

        // first frame of writes: 1,2,3,4 at 0..3
        wr_burst(4, 1, -1);
        chk("wr_ptr_after4", 32'(last_wa), 32'(3));
        // read pulse mid-stream stalls the writer for one cycle
        wr_burst(6, 0, 2);
        tick(); tick();
        // full-depth wrap: D+1 writes, the last one lands on address 0
        wr_burst(D + 1, 1, -1);
        chk("wrap_last_addr", 32'(last_wa), 32'(0));

        // frame_start with a read in the same cycle while rd_ptr sits at 900
        frame_start = 1; rd_req = 1;
        tick();
        frame_start = 0;
`ifndef FB_LINE_DOUBLE_EN
        for (int i = 0; i < 899; i++) begin
            rd_req = 1; line_start = (i == 400);
            tick();
        end
`else
        reads(899);
`endif
        idle();
        chk("rd_ptr_900", 32'(last_ra), 32'(899));
        frame_start = 1; rd_req = 1;
        tick();
        chk("fs_addr", 32'(last_ra), 32'(0));
        frame_start = 0;
        tick();
        chk("fs_next_addr", 32'(last_ra), 32'(1));
        idle();
        tick(); tick();

        // clear to colour 5 with 10 interleaved reads
        run_clear(3'd5, 100, -1, D + 10);
        frame_start = 1; rd_req = 1;
        tick();
        frame_start = 0;
        reads(40);
        tick(); tick();
        chk("ref_after_clear", 32'(ref_mem[1500]), 32'(5));

        // a second clear_start during a clear is ignored
        run_clear(3'd2, D + 500, 10, D);
        reads(5);
        tick(); tick();

        // reset abandons a clear; writer restarts at address 0
        clear_color = 3'd7; clear_start = 1;
        tick();
        clear_start = 0;
        for (int i = 0; i < 50; i++) tick();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
        wr_burst(3, 0, -1);
        chk("post_reset_wr", 32'(last_wa), 32'(2));
        tick(); tick();

`ifdef FB_LINE_DOUBLE_EN
        // each stored line is scanned twice
        frame_start = 1;
        tick();
        frame_start = 0; line_start = 1;
        tick();
        line_start = 0;
        reads(640);
        chk("ld_line0_end", 32'(last_ra), 32'(639));
        line_start = 1;
        tick();
        line_start = 0;
        m_rd_ptr = 0;
        reads(640);
        chk("ld_repeat_end", 32'(last_ra), 32'(639));
        line_start = 1;
        tick();
        line_start = 0;
        reads(640);
        chk("ld_line1_end", 32'(last_ra), 32'(1279));
        tick(); tick();
`endif

        chk("rdq_drained", 32'(rdq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Sequencer and arbiter for the single-port 3-bit frame buffer RAM (640x240 pixels, 19-bit address, registered read data).
- Shares the RAM between the VGA scan-out reader, which has hard priority, and a pixel writer that uses a valid/ready handshake.
- Owns all frame-buffer address counters.
- Provides a hardware frame-clear sequence that fills the buffer with one colour.

Parameters:
- WIDTH, 3, pixel width in bits
- DEPTH, 153600 (640*240), number of pixels in the frame buffer
- AW, 19, address width

Ports:
- clk_50  in  1  system clock, all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse from the display timing block at the start of a frame
- line_start  in  1  one-cycle pulse from the display timing block at the start of each visible line
- rd_req  in  1  display requests the next pixel this cycle
- rd_valid  out  1  rd_pixel is valid this cycle
- rd_pixel  out  WIDTH  pixel returned to the display
- wr_valid  in  1  writer offers wr_pixel
- wr_ready  out  1  arbiter accepts wr_pixel this cycle
- wr_pixel  in  WIDTH  pixel to store
- wr_sof  in  1  qualifies wr_pixel as the first pixel of a frame
- clear_start  in  1  one-cycle pulse that starts a frame clear
- clear_color  in  WIDTH  fill colour, sampled on clear_start
- clear_busy  out  1  a clear is in progress
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, valid 1 cycle after mem_addr is presented

Behaviour:
- Reset values:
  - rd_ptr, wr_ptr and clr_ptr = 0; state = NORMAL.
  - rd_valid = 0, clear_busy = 0, mem_we = 0.
  - wr_ready = 0 while reset_n is low.
  - A clear in progress is abandoned on reset; there is no resume.
- States:
  - NORMAL: the writer is served. clear_start moves to CLEAR, latching clear_color and setting clr_ptr = 0.
  - CLEAR: the writer is stalled. One fill write per non-read cycle. When the write at clr_ptr == DEPTH-1 completes, return to NORMAL.
  - clear_start received while already in CLEAR is ignored.
- Arbitration (per cycle, fixed priority):
  1. rd_req: mem_addr = rd_ptr, mem_we = 0.
  2. CLEAR: mem_addr = clr_ptr, mem_we = 1, mem_wdata = latched colour.
  3. NORMAL and wr_valid: mem_addr = wr_ptr, mem_we = 1, mem_wdata = wr_pixel.
- wr_ready:
  - Combinational: wr_ready = reset_n & !rd_req & (state == NORMAL).
  - A transfer occurs only when wr_valid & wr_ready.
  - The writer must hold wr_pixel and wr_sof stable until the transfer.
- Read latency:
  - rd_valid is asserted exactly 1 cycle after an accepted rd_req.
  - rd_pixel = mem_rdata in that cycle.
  - Back-to-back rd_req gives rd_valid on every following cycle.
- Pointer wrap:
  - Each pointer increments only on its own serviced access.
  - Each pointer wraps from DEPTH-1 to 0 with no skipped address.
- frame_start:
  - rd_ptr is forced to 0.
  - If rd_req is in the same cycle, the read uses address 0 and rd_ptr becomes 1.
- wr_sof on a transfer: the pixel is written at address 0 and wr_ptr becomes 1, whatever the previous wr_ptr.
- wr_sof while stalled has no effect until the transfer occurs.
- clear_busy = 1 exactly while state == CLEAR.
- Clear duration: DEPTH fill cycles plus one cycle for every cycle in which rd_req is high.
- wr_ptr is not modified by a clear.
- line_start is ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: FB_LINE_DOUBLE_EN
- With the macro defined, each stored 640-pixel line is scanned twice, giving 480 displayed lines:
  - A parity bit and a line_base register are kept; frame_start sets parity = 0 and line_base = 0.
  - On line_start with parity 0: line_base <= rd_ptr, parity <= 1.
  - On line_start with parity 1: rd_ptr <= line_base, parity <= 0.
  - frame_start takes precedence over line_start in the same cycle.
- Without the macro: line_start is unused, and no parity bit or line_base register exists.

Test Plan:
- Reset release, writer drives 4 pixels 1,2,3,4 with wr_sof on the first pixel, no reads -> mem_we high for 4 cycles at addresses 0..3 with data 1..4; wr_ptr = 4.
- wr_valid held high and rd_req pulsed for 1 cycle mid-stream -> wr_ready low in that cycle; mem_addr = rd_ptr; rd_valid 1 cycle later returns the stored pixel; no write is lost or duplicated.
- 153601 consecutive writes -> the last write lands at address 0 (wrap from 153599); the pointer never reaches 153600.
- clear_start with clear_color = 5, rd_req high in 10 of the cycles -> clear_busy high for 153610 cycles; wr_ready low throughout; a subsequent read of any address returns 5.
- frame_start and rd_req in the same cycle while rd_ptr = 900 -> mem_addr = 0; the next read uses address 1.
- FB_LINE_DOUBLE_EN defined: frame_start, then 640 reads, line_start, 640 reads, line_start, 640 reads -> addresses 0..639, then 0..639 again, then 640..1279.
